// File: rtl/random_delay.sv
// Random delay timer for the reaction-game light sequence.
// A rising edge on i_start_delay captures the PRBS value, loads a countdown of
// MIN_MS + prbs*STEP_MS tick periods, and raises o_time_out once it has elapsed.
// MIN_MS + 127*STEP_MS must fit in 12 bits (<= 4095).
module random_delay #(
  parameter int MIN_MS  = 500,
  parameter int STEP_MS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick,
  input  logic        i_start_delay,
  input  logic [6:0]  i_prbs,
  output logic        o_time_out,
  output logic        o_busy,
  output logic [11:0] o_remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [11:0] MIN_W  = 12'(MIN_MS);
  localparam logic [11:0] STEP_W = 12'(STEP_MS);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_startQ;
  logic        r_lowSeen;
  logic [6:0]  r_prbsQ;
  logic [11:0] r_remaining;
  logic [11:0] w_nextRemaining;
  logic        r_timeOut;
  logic        w_startRise;
  logic        w_startReq;
  logic [11:0] w_loadValue;

  // A start only counts once start_delay has been seen low since reset, so a
  // level that is already high when reset releases cannot launch a delay.
  assign w_startRise = i_start_delay & ~r_startQ;
  assign w_startReq  = w_startRise & r_lowSeen;

  // Fits in 12 bits by the parameter constraint, so no truncation occurs.
  assign w_loadValue = MIN_W + ({5'd0, r_prbsQ} * STEP_W);

  // Next-state and next-countdown logic; abort wins over a terminal tick.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    case (r_state)
      IDLE: begin
        w_nextRemaining = 12'd0;
        if (w_startReq) begin
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_nextRemaining = w_loadValue;
        if (w_loadValue == 12'd0) begin
          w_nextState = DONE;
        end else begin
          w_nextState = COUNT;
        end
      end
      COUNT: begin
        if (!i_start_delay) begin
          w_nextState     = IDLE;
          w_nextRemaining = 12'd0;
        end else if (i_tick && (r_remaining != 12'd0)) begin
          w_nextRemaining = r_remaining - 12'd1;
          if (r_remaining == 12'd1) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextRemaining = 12'd0;
        if (!i_start_delay) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState     = IDLE;
        w_nextRemaining = 12'd0;
      end
    endcase
  end

  // State, countdown and registered time-out flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= 12'd0;
      r_timeOut   <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
      r_timeOut   <= (w_nextState == DONE);
    end
  end

  // Start-edge detection history and PRBS capture at the moment of the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_startQ  <= 1'b0;
      r_lowSeen <= 1'b0;
      r_prbsQ   <= 7'd0;
    end else begin
      r_startQ <= i_start_delay;
      if (!i_start_delay) begin
        r_lowSeen <= 1'b1;
      end
      if ((r_state == IDLE) && w_startReq) begin
        r_prbsQ <= i_prbs;
      end
    end
  end

  assign o_busy      = (r_state == LOAD) || (r_state == COUNT);
  assign o_time_out  = r_timeOut;
  assign o_remaining = r_remaining;

endmodule

// File: tb/tb_random_delay.sv
// Self-checking bench for random_delay. Each delay is predicted from the
// arithmetic rule MIN + prbs*STEP and the ticks actually delivered, with
// randomized PRBS values and randomized tick spacing.
module tb_random_delay;

  localparam int MIN_MS  = 500;
  localparam int STEP_MS = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick;
  logic        start;
  logic [6:0]  prbs;
  logic        timeOut;
  logic        busy;
  logic [11:0] remaining;

  logic        zStart;
  logic [6:0]  zPrbs;
  logic        zTick;
  logic        zTimeOut;
  logic        zBusy;
  logic [11:0] zRemaining;

  int checkCount = 0;
  int errorCount = 0;

  random_delay #(.MIN_MS(MIN_MS), .STEP_MS(STEP_MS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (tick),
    .i_start_delay(start),
    .i_prbs       (prbs),
    .o_time_out   (timeOut),
    .o_busy       (busy),
    .o_remaining  (remaining)
  );

  random_delay #(.MIN_MS(0), .STEP_MS(20)) dutZero (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (zTick),
    .i_start_delay(zStart),
    .i_prbs       (zPrbs),
    .o_time_out   (zTimeOut),
    .o_busy       (zBusy),
    .o_remaining  (zRemaining)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic int expDelay(input int p);
    return MIN_MS + p * STEP_MS;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one delay and follow it tick by tick. With stopAt >= 0 the task
  // returns mid-count once that many ticks have been delivered; otherwise it
  // runs to time-out, holds start high for holdCycles, then releases it.
  task automatic applyStimulus(input int p, input int tickPct, input int stopAt, input int holdCycles);
    int d;
    int ticks;
    int cycles;
    int errBefore;
    d = expDelay(p);
    start = 1'b0;
    tick  = 1'b0;
    step();
    step();
    prbs  = p[6:0];
    start = 1'b1;
    step();
    checkOutput("loadBusy", {31'd0, busy}, 32'd1);
    checkOutput("loadTimeOut", {31'd0, timeOut}, 32'd0);
    prbs = 7'($urandom);
    tick = 1'b1;
    step();
    checkOutput("loadedRemaining", {20'd0, remaining}, d);
    checkOutput("countBusy", {31'd0, busy}, 32'd1);
    ticks  = 0;
    cycles = 0;
    while (ticks < d) begin
      if ((stopAt >= 0) && (ticks == stopAt)) begin
        tick = 1'b0;
        return;
      end
      tick = ($urandom_range(0, 99) < tickPct);
      step();
      if (tick) ticks++;
      cycles++;
      errBefore = errorCount;
      checkOutput("remaining", {20'd0, remaining}, d - ticks);
      checkOutput("timeOut", {31'd0, timeOut}, (ticks == d) ? 32'd1 : 32'd0);
      checkOutput("busy", {31'd0, busy}, (ticks == d) ? 32'd0 : 32'd1);
      if (errorCount != errBefore) break;
      if (cycles > 4 * d + 200) begin
        checkOutput("tickBudget", ticks, d);
        break;
      end
    end
    for (int i = 0; i < holdCycles; i++) begin
      tick = ($urandom_range(0, 99) < tickPct);
      step();
      if ((i % 100 == 0) || (i == holdCycles - 1)) begin
        checkOutput("holdTimeOut", {31'd0, timeOut}, 32'd1);
        checkOutput("holdRemaining", {20'd0, remaining}, 32'd0);
        checkOutput("holdBusy", {31'd0, busy}, 32'd0);
      end
    end
    start = 1'b0;
    tick  = 1'b0;
    step();
    checkOutput("releaseTimeOut", {31'd0, timeOut}, 32'd0);
    checkOutput("releaseBusy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int p;
    start  = 1'b1;
    tick   = 1'b0;
    prbs   = 7'd0;
    zStart = 1'b0;
    zPrbs  = 7'd0;
    zTick  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("resetTimeOut", {31'd0, timeOut}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetRemaining", {20'd0, remaining}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step();
    end
    checkOutput("heldStartIgnored", {31'd0, busy}, 32'd0);
    checkOutput("heldStartRemaining", {20'd0, remaining}, 32'd0);
    tick = 1'b0;

    $display("[TB] nominal prbs=5");
    applyStimulus(5, 70, -1, 10);
    $display("[TB] minimum prbs=0");
    applyStimulus(0, 100, -1, 3);
    $display("[TB] maximum prbs=127");
    applyStimulus(127, 90, -1, 3);
    $display("[TB] hold in DONE for 1000 clocks");
    applyStimulus($urandom_range(0, 10), 100, -1, 1000);

    $display("[TB] abort together with terminal tick");
    p = $urandom_range(0, 15);
    applyStimulus(p, 80, expDelay(p) - 1, 0);
    checkOutput("preAbortRemaining", {20'd0, remaining}, 32'd1);
    start = 1'b0;
    tick  = 1'b1;
    step();
    checkOutput("abortTimeOut", {31'd0, timeOut}, 32'd0);
    checkOutput("abortRemaining", {20'd0, remaining}, 32'd0);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    tick = 1'b0;
    step();
    checkOutput("abortTimeOutLater", {31'd0, timeOut}, 32'd0);

    $display("[TB] reset mid-count");
    applyStimulus(5, 100, 300, 0);
    checkOutput("preResetRemaining", {20'd0, remaining}, 32'd300);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetRemaining", {20'd0, remaining}, 32'd0);
    checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncResetTimeOut", {31'd0, timeOut}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick = 1'b1;
      step();
    end
    checkOutput("postResetIdleBusy", {31'd0, busy}, 32'd0);
    checkOutput("postResetIdleRemaining", {20'd0, remaining}, 32'd0);
    tick = 1'b0;
    applyStimulus($urandom_range(0, 5), 100, -1, 2);

    $display("[TB] randomized delays");
    for (int r = 0; r < 5; r++) begin
      applyStimulus($urandom_range(0, 127), $urandom_range(50, 100), -1, $urandom_range(1, 20));
    end

    $display("[TB] zero delay instance");
    zStart = 1'b0;
    step();
    step();
    zPrbs  = 7'd0;
    zStart = 1'b1;
    step();
    checkOutput("zeroLoadBusy", {31'd0, zBusy}, 32'd1);
    checkOutput("zeroLoadTimeOut", {31'd0, zTimeOut}, 32'd0);
    step();
    checkOutput("zeroDoneTimeOut", {31'd0, zTimeOut}, 32'd1);
    checkOutput("zeroDoneRemaining", {20'd0, zRemaining}, 32'd0);
    checkOutput("zeroDoneBusy", {31'd0, zBusy}, 32'd0);
    zStart = 1'b0;
    step();
    checkOutput("zeroReleaseTimeOut", {31'd0, zTimeOut}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/random_delay.md
RANDOM_DELAY -- requirements
Module: random_delay

Interface
REQ-001 Parameter MIN_MS, default 500, minimum delay in tick periods.
REQ-002 Parameter STEP_MS, default 20, tick periods added per unit of prbs.
REQ-003 Constraint: MIN_MS + 127*STEP_MS SHALL be <= 4095.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick  input  1  one-clk-wide strobe per millisecond.
REQ-007 start_delay  input  1  level from the light-sequence FSM; high requests a random delay.
REQ-008 prbs  input  7  current LFSR value, sampled at delay start.
REQ-009 time_out  output  1  high when the delay has expired; held until start_delay falls.
REQ-010 busy  output  1  high in LOAD or COUNT.
REQ-011 remaining  output  12  current countdown value in tick periods.

Function
REQ-012 States SHALL be IDLE, LOAD, COUNT and DONE, encoded in a registered state variable.
REQ-013 The block SHALL register start_delay once (start_q) and define start_rise = start_delay & ~start_q.
REQ-014 IDLE: on start_rise, capture prbs into prbs_q and go to LOAD; otherwise stay; start_delay held high without a rise SHALL NOT start a delay.
REQ-015 LOAD (exactly one cycle): remaining <= MIN_MS + prbs_q*STEP_MS, computed at 12-bit width with no truncation; tick during LOAD SHALL be ignored.
REQ-016 LOAD -> DONE directly if the computed value is 0; otherwise LOAD -> COUNT.
REQ-017 COUNT: each tick decrements remaining by 1; the tick that takes remaining from 1 to 0 SHALL move the state to DONE.
REQ-018 COUNT: start_delay low SHALL move the state to IDLE (abort) and clear remaining to 0; abort SHALL take priority over a simultaneous terminal tick.
REQ-019 DONE: time_out = 1; remaining = 0; stay until start_delay is low, then go to IDLE.
REQ-020 time_out SHALL be registered and SHALL assert in the clk cycle after the terminal tick edge.
REQ-021 The total delay from start_rise to time_out SHALL be MIN_MS + prbs*STEP_MS ticks, in the range 500..3040 with default parameters.
REQ-022 remaining SHALL never wrap below 0 or exceed 4095; decrement is permitted only when remaining > 0.
REQ-023 A new start_rise SHALL be ignored while in LOAD, COUNT or DONE.
REQ-024 prbs changes after capture SHALL NOT affect the delay in progress.
REQ-025 busy SHALL be derived combinationally from state (LOAD or COUNT).

Reset
REQ-026 While rst_n = 0: state = IDLE, start_q = 0, prbs_q = 0, remaining = 0, time_out = 0, busy = 0, all asynchronously.
REQ-027 Reset asserted mid-COUNT or in DONE SHALL abort immediately.
REQ-028 After reset release, a start_delay already high SHALL NOT start a delay until it falls and rises again.

Verification
REQ-029 Nominal: rst_n released, prbs = 7'd5, start_delay rises -> LOAD sets remaining = 600; time_out rises 1 clk after the 600th tick; busy low in DONE.
REQ-030 Extremes: prbs = 0 gives 500 ticks; prbs = 127 gives remaining = 3040 with no overflow; time_out occurs at the 3040th tick.
REQ-031 Abort: start_delay falls with the terminal tick in the same cycle -> IDLE, time_out stays 0, remaining = 0.
REQ-032 Zero delay: MIN_MS = 0, STEP_MS = 20, prbs = 0 -> LOAD -> DONE; time_out high 2 clks after start_rise with no tick.
REQ-033 Reset mid-count: rst_n low at remaining = 300 -> all outputs 0 asynchronously; release with start_delay high -> stays IDLE until a fresh rise.
REQ-034 Hold and release: in DONE, start_delay held high for 1000 clks keeps time_out = 1; start_delay low -> time_out = 0 on the next clk and state returns to IDLE.
